// File: rtl/gen_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// gen_sequencer_pkg
// Purpose : Shared definitions for the generation sequencer slice: the FSM
//           state type, the default generation-counter width and a small
//           helper that classifies states as "generation in flight".
// Ports   : none (package).
// Config  : the ERROR state is only reachable when GEN_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
package gen_sequencer_pkg;

   localparam int unsigned GEN_W_DEFAULT = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_GUARD = 3'd2,
      ST_RUN   = 3'd3,
      ST_SYNC  = 3'd4,
      ST_ERROR = 3'd5
   } seq_state_t;

   // A generation is in flight from the start pulse until the buffer swap.
   function automatic logic state_is_busy(input seq_state_t s);
      return (s == ST_START) || (s == ST_GUARD) || (s == ST_RUN) || (s == ST_SYNC);
   endfunction

endpackage

// File: rtl/gen_watchdog.sv
// -----------------------------------------------------------------------------
// gen_watchdog
// Purpose : Cycle counter that flags a generation which runs too long.
//           Counts while enabled, saturates at WDT_CYCLES-1 and reports
//           expiry there; a clear returns it to zero.
// Ports   : i_clk      - clock, rising edge
//           i_rst_n    - asynchronous active-low reset
//           i_clear    - synchronous clear of the count
//           i_enable   - count this cycle
//           o_expired  - count has reached WDT_CYCLES-1
// Config  : only instantiated when GEN_WATCHDOG_EN is defined.
// -----------------------------------------------------------------------------
module gen_watchdog
   import gen_sequencer_pkg::*;
#(
   parameter int unsigned WDT_CYCLES = 2**20
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int unsigned      LP_W    = $clog2(WDT_CYCLES) + 1;
   localparam logic [LP_W-1:0]  LP_LAST = LP_W'(WDT_CYCLES - 1);

   logic [LP_W-1:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_expired) begin
         r_cnt <= r_cnt + LP_W'(1);
      end
   end

   assign o_expired = (r_cnt == LP_LAST);

endmodule

// File: rtl/gen_sequencer.sv
// -----------------------------------------------------------------------------
// gen_sequencer
// Purpose : Paces a life-logic engine against the display. A generation is
//           launched on a frame tick (free-running or single-stepped), the
//           engine's done flag is masked for GUARD_CYCLES after the start
//           pulse, and the double buffer is swapped and the generation count
//           bumped on the first frame tick after done.
// Ports   : clk_in           - sole clock, rising edge
//           rst_n_in         - asynchronous active-low reset
//           frame_tick_in    - one-cycle pulse at start of vertical blanking
//           run_in           - level, free-running generations when high
//           step_in          - pulse, request one generation while paused
//           logic_done_in    - done flag from the life logic engine
//           logic_start_out  - one-cycle start pulse to the engine
//           buf_sel_out      - displayed/read half of the double buffer
//           gen_count_out    - completed-generation count (wraps)
//           busy_out         - generation in flight
//           err_out          - sticky watchdog error
// Config  : GEN_WATCHDOG_EN - adds gen_watchdog and the ERROR state; without
//           it err_out is tied low and RUN waits for done indefinitely.
// -----------------------------------------------------------------------------
module gen_sequencer
   import gen_sequencer_pkg::*;
#(
   parameter int unsigned GEN_W        = GEN_W_DEFAULT,
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned WDT_CYCLES   = 2**20
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             frame_tick_in,
   input  logic             run_in,
   input  logic             step_in,
   input  logic             logic_done_in,
   output logic             logic_start_out,
   output logic             buf_sel_out,
   output logic [GEN_W-1:0] gen_count_out,
   output logic             busy_out,
   output logic             err_out
);

   localparam int unsigned       LP_GW         = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam logic [LP_GW-1:0]  LP_GUARD_LAST = LP_GW'(GUARD_CYCLES - 1);

   seq_state_t       r_state;
   seq_state_t       w_state_nxt;
   logic [1:0]       r_rst_sync;
   logic             w_rst_ok;
   logic             r_step_pending;
   logic [LP_GW-1:0] r_guard_cnt;
   logic             w_guard_end;
   logic             r_buf_sel;
   logic [GEN_W-1:0] r_gen_count;
   logic             w_go;
   logic             w_commit;

   // Reset release is retimed through two flops; the FSM may only leave IDLE
   // once the synchronised release has arrived.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_rst_sync <= '0;
      end else begin
         r_rst_sync <= {r_rst_sync[0], 1'b1};
      end
   end

   assign w_rst_ok    = r_rst_sync[1];
   assign w_guard_end = (r_guard_cnt == LP_GUARD_LAST);

`ifdef GEN_WATCHDOG_EN
   logic w_wdt_enable;
   logic w_wdt_clear;
   logic w_wdt_expired;

   assign w_wdt_enable = (r_state == ST_GUARD) || (r_state == ST_RUN);
   assign w_wdt_clear  = ~w_wdt_enable;

   gen_watchdog #(
      .WDT_CYCLES (WDT_CYCLES)
   ) u_watchdog (
      .i_clk     (clk_in),
      .i_rst_n   (rst_n_in),
      .i_clear   (w_wdt_clear),
      .i_enable  (w_wdt_enable),
      .o_expired (w_wdt_expired)
   );
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_go        = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (frame_tick_in && w_rst_ok && (run_in || r_step_pending)) begin
               w_state_nxt = ST_START;
               w_go        = 1'b1;
            end
         end
         ST_START: begin
            w_state_nxt = ST_GUARD;
         end
         ST_GUARD: begin
`ifdef GEN_WATCHDOG_EN
            if (w_wdt_expired) begin
               w_state_nxt = ST_ERROR;
            end else if (w_guard_end) begin
               w_state_nxt = ST_RUN;
            end
`else
            if (w_guard_end) begin
               w_state_nxt = ST_RUN;
            end
`endif
         end
         ST_RUN: begin
            // A done sampled on the expiry cycle still completes the generation.
            if (logic_done_in) begin
               w_state_nxt = ST_SYNC;
`ifdef GEN_WATCHDOG_EN
            end else if (w_wdt_expired) begin
               w_state_nxt = ST_ERROR;
`endif
            end
         end
         ST_SYNC: begin
            // Returning to IDLE here means the same tick cannot also launch
            // the next generation.
            if (frame_tick_in) begin
               w_state_nxt = ST_IDLE;
               w_commit    = 1'b1;
            end
         end
`ifdef GEN_WATCHDOG_EN
         ST_ERROR: begin
            w_state_nxt = ST_ERROR;
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state        <= ST_IDLE;
         r_step_pending <= 1'b0;
         r_guard_cnt    <= '0;
         r_buf_sel      <= 1'b0;
         r_gen_count    <= '0;
      end else begin
         r_state <= w_state_nxt;
         // A step arriving on the very cycle a generation launches is kept
         // for the following tick rather than being lost.
         r_step_pending <= step_in | (r_step_pending & ~w_go);
         if (r_state == ST_GUARD) begin
            r_guard_cnt <= r_guard_cnt + LP_GW'(1);
         end else begin
            r_guard_cnt <= '0;
         end
         if (w_commit) begin
            r_buf_sel   <= ~r_buf_sel;
            r_gen_count <= r_gen_count + GEN_W'(1);
         end
      end
   end

   assign logic_start_out = (r_state == ST_START);
   assign busy_out        = state_is_busy(r_state);
   assign buf_sel_out     = r_buf_sel;
   assign gen_count_out   = r_gen_count;

`ifdef GEN_WATCHDOG_EN
   assign err_out = (r_state == ST_ERROR);
`else
   assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_gen_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gen_sequencer
// Purpose : Self-checking bench for gen_sequencer. Each segment builds a
//           stimulus schedule (ticks, run level, steps), a timeline model
//           derives start/swap times and the engine's done pattern from it,
//           expected events are queued, and a monitor compares the DUT's
//           start pulses, buffer swaps and busy level against the queues.
//           Every segment ends with an asynchronous reset.
// Config  : with GEN_WATCHDOG_EN defined an extra watchdog segment is run.
// -----------------------------------------------------------------------------
module tb_gen_sequencer;

   localparam int unsigned GW   = 4;
   localparam int unsigned GC   = 4;
   localparam int unsigned WDT  = 64;
   localparam int          MAXN = 1600;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic          run = 1'b0;
   logic          step = 1'b0;
   logic          done = 1'b0;
   logic          start;
   logic          bufsel;
   logic [GW-1:0] cnt;
   logic          busy;
   logic          err;

   gen_sequencer #(
      .GEN_W        (GW),
      .GUARD_CYCLES (GC),
      .WDT_CYCLES   (WDT)
   ) dut (
      .clk_in          (clk),
      .rst_n_in        (rst_n),
      .frame_tick_in   (tick),
      .run_in          (run),
      .step_in         (step),
      .logic_done_in   (done),
      .logic_start_out (start),
      .buf_sel_out     (bufsel),
      .gen_count_out   (cnt),
      .busy_out        (busy),
      .err_out         (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int e;
      int c;
      bit b;
   } commit_t;

   bit      a_tick [MAXN+1];
   bit      a_run  [MAXN+1];
   bit      a_step [MAXN+1];
   bit      a_done [MAXN+1];
   bit      a_busy [MAXN+1];
   int      sq[$];
   commit_t cq[$];

   int            n_checks = 0;
   int            n_fail   = 0;
   int            edge_idx = 0;
   bit            mon_en   = 1'b0;
   logic [GW-1:0] prev_cnt = '0;
   logic          prev_buf = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_idx, act, exp);
      end
   endtask

   task automatic gen_seg(input int n, input int prof);
      int nt;
      bit r;
      for (int c = 0; c <= MAXN; c++) begin
         a_tick[c] = 0; a_run[c] = 0; a_step[c] = 0; a_done[c] = 0; a_busy[c] = 0;
      end
      a_tick[2] = 1;  // lands before the synchronised reset release: must be ignored
      case (prof)
         0: begin
            for (int c = 1; c <= n; c++) a_run[c] = 1;
            for (int c = 10; c <= n; c += 40) a_tick[c] = 1;
         end
         1: begin
            a_step[5] = 1;
            a_step[8] = 1;
            for (int c = 30; c <= n; c += 30) a_tick[c] = 1;
         end
         default: begin
            r  = 1'($urandom_range(0, 1));
            nt = 2 + int'($urandom_range(3, 30));
            for (int c = 1; c <= n; c++) begin
               if ($urandom_range(0, 149) == 0) r = !r;
               a_run[c]  = r;
               a_step[c] = ($urandom_range(0, 49) == 0);
               if (c == nt) begin
                  a_tick[c] = 1;
                  nt = c + int'($urandom_range(3, 30));
               end
            end
         end
      endcase
   endtask

   // Timeline model: launches on an eligible tick once reset has been released
   // for two edges, done counts only from GC+2 edges after the launch, and the
   // swap happens on the first tick after done was taken.
   task automatic run_model(input int n, input int prof);
      bit busy_m = 0;
      bit pend   = 0;
      bit taken  = 0;
      bit bsel   = 0;
      int go     = 0;
      int count  = 0;
      int d, h, s;
      for (int c = 1; c <= n; c++) begin
         if (!busy_m) begin
            bit fire;
            fire = a_tick[c] && (c >= 3) && (a_run[c] || pend);
            if (fire) begin
               go = c; busy_m = 1; taken = 0;
               sq.push_back(c);
               if (prof == 0) begin
                  d = 20; h = 1; s = 1;
               end else begin
                  s = int'($urandom_range(1, GC + 1));
                  d = int'($urandom_range(1, 25));
                  if ($urandom_range(0, 1) == 1) h = n;
                  else h = (((GC + 3 - d) > 1) ? (GC + 3 - d) : 1) + int'($urandom_range(0, 2));
               end
               // A stale done from the previous generation persists s edges.
               for (int k = c + s; k <= n; k++) a_done[k] = 0;
               for (int k = c + d; k <= n && k <= c + d + h - 1; k++) a_done[k] = 1;
            end
            pend = a_step[c] | (pend & !fire);
         end else begin
            pend = pend | a_step[c];
            if (!taken) begin
               taken = (c >= go + GC + 2) && a_done[c];
            end else if (a_tick[c]) begin
               count  = (count + 1) % (1 << GW);
               bsel   = !bsel;
               cq.push_back('{c, count, bsel});
               busy_m = 0;
            end
         end
         a_busy[c] = busy_m;
      end
   endtask

   task automatic assert_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick = 0; run = 0; step = 0; done = 0;
      #1;
      check("reset_outputs", {start, bufsel, cnt, busy, err}, 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic play(input int n);
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (c == 1) begin
            prev_cnt = '0;
            prev_buf = 1'b0;
            rst_n    = 1'b1;
            mon_en   = 1'b1;
         end
         edge_idx = c;
         tick = a_tick[c]; run = a_run[c]; step = a_step[c]; done = a_done[c];
      end
      @(negedge clk);
      mon_en = 1'b0;
      check("start_leftover", sq.size(), 0);
      check("swap_leftover", cq.size(), 0);
      sq.delete();
      cq.delete();
   endtask

   task automatic do_seg(input int n, input int prof);
      gen_seg(n, prof);
      run_model(n, prof);
      play(n);
      assert_reset();
   endtask

   initial begin
      commit_t ex;
      int e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            e = edge_idx;
            if (start) begin
               if (sq.size() == 0) check("start_unexpected", e, -1);
               else check("start_edge", e, sq.pop_front());
            end
            if (cnt !== prev_cnt || bufsel !== prev_buf) begin
               if (cq.size() == 0) begin
                  check("swap_unexpected", e, -1);
               end else begin
                  ex = cq.pop_front();
                  check("swap_edge_cnt_buf", e * 1000 + int'(cnt) * 10 + int'(bufsel),
                        ex.e * 1000 + ex.c * 10 + int'(ex.b));
               end
               prev_cnt = cnt;
               prev_buf = bufsel;
            end
            check("busy", busy, a_busy[e]);
            check("err", err, 0);
         end
      end
   end

`ifdef GEN_WATCHDOG_EN
   task automatic wdt_seg();
      for (int c = 1; c <= 120; c++) begin
         @(negedge clk);
         if (c == 1) rst_n = 1'b1;
         edge_idx = c;
         run  = 1'b1;
         step = 1'b0;
         done = 1'b0;
         tick = (c == 10 || c == 40 || c == 90 || c == 100);
         @(posedge clk);
         #1;
         if (c == 10) check("wdt_start", start, 1);
         if (c == 74) check("wdt_before_expiry", {err, busy}, 2'b01);
         if (c == 75) check("wdt_expired", {err, busy}, 2'b10);
         if (c > 75) check("wdt_error_hold", {start, err, busy, bufsel, cnt}, {3'b010, 1'b0, GW'(0)});
      end
      assert_reset();
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      #1;
      check("reset_outputs_initial", {start, bufsel, cnt, busy, err}, 0);
      repeat (3) @(negedge clk);
      do_seg(1385, 0);
      do_seg(300, 1);
      for (int i = 0; i < 4; i++) do_seg(800, 2);
`ifdef GEN_WATCHDOG_EN
      wdt_seg();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
